// File: rtl/core_pkg.sv
// Shared constants for the pipeline core: control-bit layout and default widths.
package core_pkg;

   localparam int unsigned CTRL_W        = 8;
   localparam int unsigned CTRL_REGWRITE = 7;
   localparam int unsigned CTRL_MEMTOREG = 6;
   localparam int unsigned CTRL_MEMREAD  = 5;
   localparam int unsigned CTRL_MEMWRITE = 4;
   localparam int unsigned CTRL_ALUSRC   = 3;
   localparam int unsigned CTRL_REGDST   = 2;
   localparam int unsigned CTRL_ALUOP_HI = 1;
   localparam int unsigned CTRL_ALUOP_LO = 0;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/id_ex_register_if.sv
// Decode/execute boundary signals, including the write-back bypass port.
interface id_ex_register_if
   import core_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned CNT_W  = 16
);

   logic              stall_i;
   logic              flush_i;
   logic              valid_i;
   logic [ADDR_W-1:0] rsaddr_i;
   logic [ADDR_W-1:0] rtaddr_i;
   logic [DATA_W-1:0] rsdata_i;
   logic [DATA_W-1:0] rtdata_i;
   logic [DATA_W-1:0] imm_i;
   logic [ADDR_W-1:0] rdaddr_i;
   logic [CTRL_W-1:0] ctrl_i;
   logic              wb_regwrite_i;
   logic [ADDR_W-1:0] wb_writeaddr_i;
   logic [DATA_W-1:0] wb_writedata_i;

   logic              valid_o;
   logic [ADDR_W-1:0] rsaddr_o;
   logic [ADDR_W-1:0] rtaddr_o;
   logic [ADDR_W-1:0] rdaddr_o;
   logic [DATA_W-1:0] rsdata_o;
   logic [DATA_W-1:0] rtdata_o;
   logic [DATA_W-1:0] imm_o;
   logic [CTRL_W-1:0] ctrl_o;
   logic              hazard_stall_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport master (
      output stall_i, flush_i, valid_i, rsaddr_i, rtaddr_i, rsdata_i, rtdata_i, imm_i,
             rdaddr_i, ctrl_i, wb_regwrite_i, wb_writeaddr_i, wb_writedata_i,
      input  valid_o, rsaddr_o, rtaddr_o, rdaddr_o, rsdata_o, rtdata_o, imm_o, ctrl_o,
             hazard_stall_o, bubble_cnt_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, rsaddr_i, rtaddr_i, rsdata_i, rtdata_i, imm_i,
             rdaddr_i, ctrl_i, wb_regwrite_i, wb_writeaddr_i, wb_writedata_i,
      output valid_o, rsaddr_o, rtaddr_o, rdaddr_o, rsdata_o, rtdata_o, imm_o, ctrl_o,
             hazard_stall_o, bubble_cnt_o
   );

endinterface

// File: rtl/wb_bypass_mux.sv
// Selects write-back data over register-file data on an address match; r0 always reads 0.
module wb_bypass_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = rd_data;
      if (addr == '0) begin
         result = '0;
      end else if (wb_we && (wb_addr == addr)) begin
         result = wb_data;
      end
   end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion, stall and flush.
module id_ex_register
   import core_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned CNT_W  = 16
) (
   input logic             clk_i,
   input logic             rst_i,
   id_ex_register_if.slave bus
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] rsaddr_q, rsaddr_d;
   logic [ADDR_W-1:0] rtaddr_q, rtaddr_d;
   logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
   logic [DATA_W-1:0] rsdata_q, rsdata_d;
   logic [DATA_W-1:0] rtdata_q, rtdata_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

   logic              hazard;
   logic              bubble;
   logic [DATA_W-1:0] byp_rs, byp_rt, hold_rs, hold_rt;

   // Capture-side bypass: register file writes on the same edge we sample its read port.
   wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rs (
      .addr    (bus.rsaddr_i),
      .rd_data (bus.rsdata_i),
      .wb_we   (bus.wb_regwrite_i),
      .wb_addr (bus.wb_writeaddr_i),
      .wb_data (bus.wb_writedata_i),
      .result  (byp_rs)
   );

   wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rt (
      .addr    (bus.rtaddr_i),
      .rd_data (bus.rtdata_i),
      .wb_we   (bus.wb_regwrite_i),
      .wb_addr (bus.wb_writeaddr_i),
      .wb_data (bus.wb_writedata_i),
      .result  (byp_rt)
   );

   // Hold-side refresh: keeps stalled operands current with retiring writes.
   wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold_rs (
      .addr    (rsaddr_q),
      .rd_data (rsdata_q),
      .wb_we   (bus.wb_regwrite_i),
      .wb_addr (bus.wb_writeaddr_i),
      .wb_data (bus.wb_writedata_i),
      .result  (hold_rs)
   );

   wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold_rt (
      .addr    (rtaddr_q),
      .rd_data (rtdata_q),
      .wb_we   (bus.wb_regwrite_i),
      .wb_addr (bus.wb_writeaddr_i),
      .wb_data (bus.wb_writedata_i),
      .result  (hold_rt)
   );

   assign hazard = valid_q && ctrl_q[CTRL_MEMREAD] && (rtaddr_q != '0) && bus.valid_i &&
                   ((rtaddr_q == bus.rsaddr_i) || (rtaddr_q == bus.rtaddr_i));

   assign bubble  = bus.flush_i || (!bus.stall_i && hazard);
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      valid_d  = valid_q;
      rsaddr_d = rsaddr_q;
      rtaddr_d = rtaddr_q;
      rdaddr_d = rdaddr_q;
      rsdata_d = rsdata_q;
      rtdata_d = rtdata_q;
      imm_d    = imm_q;
      ctrl_d   = ctrl_q;
      cnt_d    = cnt_q;
      if (bubble) begin
         valid_d  = 1'b0;
         rsaddr_d = '0;
         rtaddr_d = '0;
         rdaddr_d = '0;
         rsdata_d = '0;
         rtdata_d = '0;
         imm_d    = '0;
         ctrl_d   = '0;
         cnt_d    = cnt_inc;
      end else if (bus.stall_i) begin
         rsdata_d = hold_rs;
         rtdata_d = hold_rt;
      end else begin
         valid_d  = bus.valid_i;
         rsaddr_d = bus.rsaddr_i;
         rtaddr_d = bus.rtaddr_i;
         rdaddr_d = bus.rdaddr_i;
         rsdata_d = byp_rs;
         rtdata_d = byp_rt;
         imm_d    = bus.imm_i;
         ctrl_d   = bus.valid_i ? bus.ctrl_i : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q  <= 1'b0;
         rsaddr_q <= '0;
         rtaddr_q <= '0;
         rdaddr_q <= '0;
         rsdata_q <= '0;
         rtdata_q <= '0;
         imm_q    <= '0;
         ctrl_q   <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         rsaddr_q <= rsaddr_d;
         rtaddr_q <= rtaddr_d;
         rdaddr_q <= rdaddr_d;
         rsdata_q <= rsdata_d;
         rtdata_q <= rtdata_d;
         imm_q    <= imm_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.valid_o        = valid_q;
   assign bus.rsaddr_o       = rsaddr_q;
   assign bus.rtaddr_o       = rtaddr_q;
   assign bus.rdaddr_o       = rdaddr_q;
   assign bus.rsdata_o       = rsdata_q;
   assign bus.rtdata_o       = rtdata_q;
   assign bus.imm_o          = imm_q;
   assign bus.ctrl_o         = ctrl_q;
   assign bus.hazard_stall_o = hazard;
   assign bus.bubble_cnt_o   = cnt_q;

endmodule
